scan_decoder: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with enable, blanking mask and an autonomous scan mode.
- Direct mode: decodes an SEL_W-bit select into a 2**SEL_W one-hot output.
- Scan mode: steps the active output through every index at a programmable rate.
- Drives digit/anode selects for multiplexed 7-segment displays and row strobes on the lab FPGA boards.
- Replaces the fixed 2-to-4 combinational decoder in new designs.

---
 rtl/scan_decoder.sv | 73 +++++++
 tb/tb_scan_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with enable, blanking mask and an
// autonomous scan mode, used for display digit selects and row strobes.
module scan_decoder #(
  parameter int SEL_W      = 2,
  parameter int PRESCALE   = 16,
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      x,
  input  logic [2**SEL_W-1:0]   blank_mask,
  output logic [2**SEL_W-1:0]   y,
  output logic [SEL_W-1:0]      idx,
  output logic                  step
);

  localparam int N  = 2**SEL_W;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [N-1:0]  IDLE = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};

  logic [PW-1:0]    pre, pre_next;
  logic [SEL_W-1:0] idx_next;
  logic             step_next;
  logic [N-1:0]     y_next;
  int               sel;

  // y is decoded from the next index so y and idx always update together.
  always_comb begin
    idx_next  = idx;
    pre_next  = pre;
    step_next = 1'b0;
    if (en) begin
      if (!mode) begin
        idx_next  = x;
        pre_next  = '0;
        step_next = (x != idx);
      end else if (pre == LAST) begin
        pre_next  = '0;
        idx_next  = idx + SEL_W'(1);
        step_next = 1'b1;
      end else begin
        pre_next  = pre + PW'(1);
      end
    end

    sel    = MSB_FIRST ? (N - 1 - int'(idx_next)) : int'(idx_next);
    y_next = IDLE;
    for (int i = 0; i < N; i++) begin
      if (en && (i == sel) && !blank_mask[i]) begin
        y_next[i] = ~IDLE[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      pre  <= '0;
      step <= 1'b0;
      y    <= IDLE;
    end else begin
      idx  <= idx_next;
      pre  <= pre_next;
      step <= step_next;
      y    <= y_next;
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder using three parameter sets:
// a (2-bit, prescale 4, active-high, MSB first), b (2-bit, prescale 1,
// active-low, LSB first) and c (3-bit, prescale 8, active-high, MSB first).
module tb_scan_decoder;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic       a_en, a_mode;
  logic [1:0] a_x, a_idx;
  logic [3:0] a_mask, a_y;
  logic       a_step;

  logic       b_en, b_mode;
  logic [1:0] b_x, b_idx;
  logic [3:0] b_mask, b_y;
  logic       b_step;

  logic       c_en, c_mode;
  logic [2:0] c_x, c_idx;
  logic [7:0] c_mask, c_y;
  logic       c_step;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(2), .PRESCALE(4), .ACTIVE_LOW(1'b0), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .en(a_en), .mode(a_mode), .x(a_x),
    .blank_mask(a_mask), .y(a_y), .idx(a_idx), .step(a_step));

  scan_decoder #(.SEL_W(2), .PRESCALE(1), .ACTIVE_LOW(1'b1), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .mode(b_mode), .x(b_x),
    .blank_mask(b_mask), .y(b_y), .idx(b_idx), .step(b_step));

  scan_decoder #(.SEL_W(3), .PRESCALE(8), .ACTIVE_LOW(1'b0), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .reset(reset), .en(c_en), .mode(c_mode), .x(c_x),
    .blank_mask(c_mask), .y(c_y), .idx(c_idx), .step(c_step));

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic en, input logic mode,
                               input logic [1:0] x, input logic [3:0] mask);
    a_en = en; a_mode = mode; a_x = x; a_mask = mask;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkA(input string tag, input logic [3:0] ey,
                        input logic [1:0] ei, input logic es);
    checkOutput({tag, ".y"}, 32'(a_y), 32'(ey));
    checkOutput({tag, ".idx"}, 32'(a_idx), 32'(ei));
    checkOutput({tag, ".step"}, 32'(a_step), 32'(es));
  endtask

  initial begin
    logic [3:0] sweep_y [4];
    sweep_y[0] = 4'b1000; sweep_y[1] = 4'b0100;
    sweep_y[2] = 4'b0010; sweep_y[3] = 4'b0001;

    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd0, 4'b0000);
    b_en = 1'b1; b_mode = 1'b0; b_x = 2'd0; b_mask = 4'b0000;
    c_en = 1'b1; c_mode = 1'b0; c_x = 3'd0; c_mask = 8'h00;

    // Reset state on all three instances.
    tick(2);
    checkA("reset_a", 4'b0000, 2'd0, 1'b0);
    checkOutput("reset_b.y", 32'(b_y), 32'h0000000F);
    checkOutput("reset_c.y", 32'(c_y), 32'h00000000);
    checkOutput("reset_c.idx", 32'(c_idx), 32'd0);

    reset = 1'b0;
    tick(1);
    checkA("release", 4'b1000, 2'd0, 1'b0);
    checkOutput("release_b.y", 32'(b_y), 32'h0000000E);

    // Direct sweep, then a repeated value must not pulse step.
    for (int v = 1; v < 4; v++) begin
      applyStimulus(1'b1, 1'b0, 2'(v), 4'b0000);
      tick(1);
      checkA($sformatf("sweep%0d", v), sweep_y[v], 2'(v), 1'b1);
    end
    tick(1);
    checkA("sweep_hold", 4'b0001, 2'd3, 1'b0);

    // Scan from idx 3: wraps to 0 after 4 cycles, then one step every 4.
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b0000);
    tick(3);
    checkA("scan_wait", 4'b0001, 2'd3, 1'b0);
    tick(1);
    checkA("scan_wrap", 4'b1000, 2'd0, 1'b1);
    for (int v = 1; v < 4; v++) begin
      tick(3);
      checkOutput($sformatf("scan_gap%0d.step", v), 32'(a_step), 32'd0);
      tick(1);
      checkA($sformatf("scan_step%0d", v), sweep_y[v], 2'(v), 1'b1);
    end

    // Freeze with prescaler at 2, then resume: step exactly 2 cycles later.
    tick(2);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b0000);
    tick(1);
    checkA("freeze_first", 4'b0000, 2'd3, 1'b0);
    tick(9);
    checkA("freeze_last", 4'b0000, 2'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b0000);
    tick(1);
    checkA("resume1", 4'b0001, 2'd3, 1'b0);
    tick(1);
    checkA("resume2", 4'b1000, 2'd0, 1'b1);

    // Mask change landing in a step cycle blanks the newly selected bit.
    tick(3);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b0100);
    tick(1);
    checkA("mask_step", 4'b0000, 2'd1, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b0000);
    tick(1);
    checkA("mask_clear", 4'b0100, 2'd1, 1'b0);

    // Scan back to direct loads x on the next edge.
    applyStimulus(1'b1, 1'b0, 2'd2, 4'b0000);
    tick(1);
    checkA("to_direct", 4'b0010, 2'd2, 1'b1);

    // Active-low, LSB-first blanking and restore.
    b_x = 2'd1; b_mask = 4'b0010;
    tick(1);
    checkOutput("blank_b.y", 32'(b_y), 32'h0000000F);
    checkOutput("blank_b.idx", 32'(b_idx), 32'd1);
    b_mask = 4'b0000;
    tick(1);
    checkOutput("unblank_b.y", 32'(b_y), 32'h0000000D);

    // PRESCALE=1: advances every cycle with step held high.
    b_mode = 1'b1;
    tick(1);
    checkOutput("p1_a.y", 32'(b_y), 32'h0000000B);
    checkOutput("p1_a.step", 32'(b_step), 32'd1);
    tick(1);
    checkOutput("p1_b.y", 32'(b_y), 32'h00000007);
    checkOutput("p1_b.step", 32'(b_step), 32'd1);
    tick(1);
    checkOutput("p1_wrap.idx", 32'(b_idx), 32'd0);
    checkOutput("p1_wrap.y", 32'(b_y), 32'h0000000E);

    // Reset mid-scan on the 3-bit instance at idx 5, prescaler 6.
    c_x = 3'd5;
    tick(1);
    checkOutput("c_direct.y", 32'(c_y), 32'h00000004);
    c_mode = 1'b1;
    tick(6);
    checkOutput("c_scan.idx", 32'(c_idx), 32'd5);
    reset = 1'b1;
    tick(1);
    checkOutput("c_reset.idx", 32'(c_idx), 32'd0);
    checkOutput("c_reset.y", 32'(c_y), 32'h00000000);
    checkOutput("c_reset.step", 32'(c_step), 32'd0);
    reset = 1'b0;
    tick(7);
    checkOutput("c_after7.idx", 32'(c_idx), 32'd0);
    checkOutput("c_after7.y", 32'(c_y), 32'h00000080);
    checkOutput("c_after7.step", 32'(c_step), 32'd0);
    tick(1);
    checkOutput("c_after8.idx", 32'(c_idx), 32'd1);
    checkOutput("c_after8.y", 32'(c_y), 32'h00000040);
    checkOutput("c_after8.step", 32'(c_step), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
